// File: rtl/data_ram_arbiter_if.sv
// Bundle of both requester ports and the data RAM port of data_ram_arbiter.
// The master side is the world outside the arbiter: CPU MEM stage, DMA/loader and the RAM.
interface data_ram_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [3:0]        sel0;
   logic [3:0]        sel1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              lock1;
   logic              ack0;
   logic              ack1;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;
   logic              ram_ce_o;
   logic              ram_we_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic [3:0]        ram_sel_o;
   logic [DATA_W-1:0] ram_data_o;
   logic [DATA_W-1:0] ram_data_i;
   logic              stallreq_o;
   logic              busy_o;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, sel0, sel1, wdata0, wdata1, lock1, ram_data_i,
      input  ack0, ack1, rdata0, rdata1, ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
             stallreq_o, busy_o
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, sel0, sel1, wdata0, wdata1, lock1, ram_data_i,
      output ack0, ack1, rdata0, rdata1, ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
             stallreq_o, busy_o
   );
endinterface

// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU (port 0) and DMA (port 1),
// with a bounded port-1 burst lock. Define DATA_ARB_STAT_EN to add grant/conflict statistics outputs.
module data_ram_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic         clk,
   input  logic         rst,
   data_ram_arbiter_if.slave bus
`ifdef DATA_ARB_STAT_EN
   ,
   output logic [31:0]  gcnt0_o,
   output logic [31:0]  gcnt1_o,
   output logic [15:0]  conf_o
`endif
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [3:0] MAX_B = 4'(MAX_BURST);

   state_t            state_r;
   state_t            state_s;
   logic              grant_s;
   logic              win_s;
   logic              gnt_r;
   logic              last_r;
   logic              we_r;
   logic [3:0]        burst_cnt_r;
   logic              ram_ce_r;
   logic              ram_we_r;
   logic [ADDR_W-1:0] ram_addr_r;
   logic [3:0]        ram_sel_r;
   logic [DATA_W-1:0] ram_data_r;
   logic              ack0_r;
   logic              ack1_r;
   logic [DATA_W-1:0] rdata0_r;
   logic [DATA_W-1:0] rdata1_r;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic and winner selection (port 1 keeps the grant while locked and under budget)
   always_comb begin
      state_s = state_r;
      grant_s = 1'b0;
      win_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               grant_s = 1'b1;
               state_s = ACCESS;
               if (bus.req0 && bus.req1) begin
                  if (!last_r) begin
                     win_s = 1'b1;
                  end else if (bus.lock1 && (burst_cnt_r < MAX_B)) begin
                     win_s = 1'b1;
                  end else begin
                     win_s = 1'b0;
                  end
               end else begin
                  win_s = bus.req1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS:  state_s = RESP;
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Grant latching, RAM drive during ACCESS, and the one-cycle response
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_r       <= 1'b0;
         last_r      <= 1'b1;
         we_r        <= 1'b0;
         burst_cnt_r <= 4'd0;
         ram_ce_r    <= 1'b0;
         ram_we_r    <= 1'b0;
         ram_addr_r  <= '0;
         ram_sel_r   <= 4'd0;
         ram_data_r  <= '0;
         ack0_r      <= 1'b0;
         ack1_r      <= 1'b0;
         rdata0_r    <= '0;
         rdata1_r    <= '0;
      end else if (grant_s) begin
         gnt_r      <= win_s;
         last_r     <= win_s;
         we_r       <= win_s ? bus.we1 : bus.we0;
         ram_ce_r   <= 1'b1;
         ram_we_r   <= win_s ? bus.we1 : bus.we0;
         ram_addr_r <= win_s ? bus.addr1 : bus.addr0;
         ram_sel_r  <= win_s ? bus.sel1 : bus.sel0;
         ram_data_r <= win_s ? bus.wdata1 : bus.wdata0;
         ack0_r     <= 1'b0;
         ack1_r     <= 1'b0;
         rdata0_r   <= '0;
         rdata1_r   <= '0;
         if (win_s && bus.lock1) begin
            burst_cnt_r <= (burst_cnt_r >= MAX_B) ? MAX_B : burst_cnt_r + 4'd1;
         end else begin
            burst_cnt_r <= 4'd0;
         end
      end else if (state_r == ACCESS) begin
         ram_ce_r   <= 1'b0;
         ram_we_r   <= 1'b0;
         ram_addr_r <= '0;
         ram_sel_r  <= 4'd0;
         ram_data_r <= '0;
         ack0_r     <= ~gnt_r;
         ack1_r     <= gnt_r;
         rdata0_r   <= (!gnt_r && !we_r) ? bus.ram_data_i : '0;
         rdata1_r   <= (gnt_r && !we_r) ? bus.ram_data_i : '0;
      end else begin
         ack0_r   <= 1'b0;
         ack1_r   <= 1'b0;
         rdata0_r <= '0;
         rdata1_r <= '0;
      end
   end

   assign bus.ram_ce_o   = ram_ce_r;
   assign bus.ram_we_o   = ram_we_r;
   assign bus.ram_addr_o = ram_addr_r;
   assign bus.ram_sel_o  = ram_sel_r;
   assign bus.ram_data_o = ram_data_r;
   assign bus.ack0       = ack0_r;
   assign bus.ack1       = ack1_r;
   assign bus.rdata0     = rdata0_r;
   assign bus.rdata1     = rdata1_r;
   assign bus.stallreq_o = bus.req0 & ~ack0_r;
   assign bus.busy_o     = (state_r != IDLE);

`ifdef DATA_ARB_STAT_EN
   logic [31:0] gcnt0_r;
   logic [31:0] gcnt1_r;
   logic [15:0] conf_r;

   // Grant and conflict statistics, free-running and wrapping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gcnt0_r <= 32'd0;
         gcnt1_r <= 32'd0;
         conf_r  <= 16'd0;
      end else if (grant_s) begin
         gcnt0_r <= win_s ? gcnt0_r : gcnt0_r + 32'd1;
         gcnt1_r <= win_s ? gcnt1_r + 32'd1 : gcnt1_r;
         conf_r  <= (bus.req0 && bus.req1) ? conf_r + 16'd1 : conf_r;
      end else begin
         gcnt0_r <= gcnt0_r;
         gcnt1_r <= gcnt1_r;
         conf_r  <= conf_r;
      end
   end

   assign gcnt0_o = gcnt0_r;
   assign gcnt1_o = gcnt1_r;
   assign conf_o  = conf_r;
`endif
endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Shares the single-port data RAM between two requesters: port 0 is the CPU MEM stage and port 1 is the DMA/program loader.
- Sits between the requesters and the data RAM, and drives the RAM's ce/we/addr/sel/data_i.
- The RAM read path is combinational and writes commit on the clock edge, so each access is sequenced as grant -> access -> response.
- Round-robin arbitration, with a bounded lock that lets port 1 run bursts.

Parameters:
- ADDR_W, 32, address width (DataAddrBus).
- DATA_W, 32, data width (DataBus).
- MAX_BURST, 4, maximum consecutive locked port-1 grants while port 0 is waiting; range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req0/req1  in  1  access request; held high until the matching ack.
- we0/we1  in  1  1 = write, 0 = read.
- addr0/addr1  in  ADDR_W  byte address.
- sel0/sel1  in  4  byte-lane select.
- wdata0/wdata1  in  DATA_W  write data.
- lock1  in  1  port 1 requests to keep the grant for its next access.
- ack0/ack1  out  1  one-cycle completion pulse.
- rdata0/rdata1  out  DATA_W  read data, valid while ackN=1.
- ram_ce_o  out  1  RAM chip enable.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_sel_o  out  4  RAM byte select.
- ram_data_o  out  DATA_W  RAM write data.
- ram_data_i  in  DATA_W  RAM read data (combinational from the RAM).
- stallreq_o  out  1  pipeline stall request to the CPU = req0 & ~ack0 (combinational).
- busy_o  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; gnt_q=0; last_q=1 (port 0 wins the first tie); burst_cnt=0.
- Also on reset: all RAM outputs=0, ack0/ack1=0, rdata0/rdata1=0.
- A reset that arrives during ACCESS aborts the access: ram_ce_o drops immediately, and no ack is issued after reset releases.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no request: remain in IDLE.
- IDLE, req0 or req1 high: choose a winner, latch its we/addr/sel/wdata/lock into registers, set gnt_q=winner, then go to ACCESS.
- Winner selection:
  - Only one port requesting: that port wins.
  - Both requesting: winner = ~last_q.
  - Exception: if last_q=1, lock1=1 and burst_cnt<MAX_BURST, port 1 wins.
- burst_cnt:
  - On a port-1 grant with lock1=1: increment, saturating at MAX_BURST.
  - On a port-1 grant with lock1=0: clear to 0.
  - On any port-0 grant: clear to 0.
- last_q is updated to the winner on every grant.
- ACCESS (exactly one cycle):
  - ram_ce_o=1; ram_we_o, ram_addr_o, ram_sel_o and ram_data_o come from the latched registers.
  - A write commits to the RAM on the closing edge of this cycle.
  - A read captures ram_data_i into rdata_q on the closing edge.
  - Next state: RESP.
- Outside ACCESS, ram_ce_o=0 and all other RAM outputs=0.
- RESP (exactly one cycle):
  - ack[gnt_q]=1; rdata[gnt_q]=rdata_q for a read, 0 for a write.
  - The non-granted port sees ack=0 and rdata=0.
  - Next state: IDLE.
- Latency: req seen in IDLE -> ack 2 cycles later. Throughput is 1 access per 3 cycles.
- A requester drops req in the cycle after it sees ack. Request fields sampled only at grant, so changes during ACCESS or RESP have no effect.
- A request raised while another port is in service waits; it is evaluated in the next IDLE.
- If lock1 is held, port 0 is starved for at most MAX_BURST port-1 accesses.
- Port 0 waiting, port 1 locked, burst_cnt already at MAX_BURST: port 0 wins at the next IDLE.
- Address and sel are passed through unchecked; the RAM handles alignment.

Optional Feature:
- Macro DATA_ARB_STAT_EN.
- When defined, add outputs:
  - gcnt0_o and gcnt1_o (32 bits each): grant counters, incremented on each grant to that port.
  - conf_o (16 bits): incremented in every IDLE cycle where req0 and req1 are both high.
  - All three wrap modulo 2^width and reset to 0.
- When undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Port-0 write: addr0=0x10, sel0=4'b1111, wdata0=0xDEADBEEF, no port-1 activity -> ram_ce_o=ram_we_o=1 for one cycle with ram_addr_o=0x10; ack0 2 cycles after req. A following port-0 read at 0x10 returns rdata0=0xDEADBEEF with ack0.
- Byte-lane write: port-1 write to 0x20 with sel1=4'b0100, wdata1=0x00AB0000 over word 0x11223344 -> read-back = 0x11AB3344.
- Contention: req0 and req1 rise together from reset -> port 0 served first (ack0), then port 1 (ack1); stallreq_o stays high until ack0.
- Locked burst with MAX_BURST=4: lock1=1, port 1 issues back-to-back requests while req0 is held -> exactly 4 port-1 acks, then ack0, then port 1 resumes.
- Reset mid-access: rst=0 asserted in ACCESS -> ram_ce_o=0 immediately, busy_o=0; after release, no ack appears and state=IDLE.
- DATA_ARB_STAT_EN: 3 contended rounds -> conf_o=3, and gcnt0_o and gcnt1_o each equal the number of acks seen on that port.
